gecko_mem_port_arbiter: RTL and testbench
=========================================

// Module: gecko_mem_port_arbiter
// PURPOSE
//  Shares one sequential memory port between the gecko instruction (port 0) and data (port 1) requesters,
//  for builds where inst and data live in a single-port RAM rather than a dual-port memory.
//  Arbitrates requests and tracks outstanding transactions in order.
//  Routes each in-order memory result back to the requester that issued it.
// PARAMETERS
//  ADDR_WIDTH       32  request address width
//  DATA_WIDTH       32  data width; byte enables are DATA_WIDTH/8 (WE_WIDTH)
//  MAX_OUTSTANDING  2   max issued-but-unanswered requests (>=1); ID FIFO depth
//  PRIORITY_MODE    0   0 = round-robin, 1 = fixed priority to port 1 (data)
// PORTS
//  clk               in   1           clock
//  rst               in   1           asynchronous, active-low reset
//  reqN_valid        in   1           N=0 (inst), N=1 (data): request valid
//  reqN_ready        out  1           request accepted when valid&ready
//  reqN_write_enable in   WE_WIDTH    byte write enables (0 = read)
//  reqN_addr         in   ADDR_WIDTH  request address
//  reqN_data         in   DATA_WIDTH  write data
//  respN_valid       out  1           result valid for requester N
//  respN_ready       in   1           requester N accepts result
//  respN_data        out  DATA_WIDTH  result data
//  mem_req_valid     out  1           request to memory
//  mem_req_ready     in   1           memory accepts request
//  mem_req_write_enable out WE_WIDTH  muxed byte enables
//  mem_req_addr      out  ADDR_WIDTH  muxed address
//  mem_req_data      out  DATA_WIDTH  muxed write data
//  mem_resp_valid    in   1           memory result valid (one per request, in order, reads and writes)
//  mem_resp_ready    out  1           result consumed
//  mem_resp_data     in   DATA_WIDTH  memory result data
// BEHAVIOUR
//  - Reset (rst=0, async): ID FIFO empty, count=0, rr pointer=0 (inst preferred next), lock clear.
//    All valid/ready outputs are 0 during and after reset until inputs demand otherwise.
//  - Request path is combinational, zero latency:
//    grant chosen among valid requesters; mem_req_* = granted request.
//    reqG_ready = mem_req_ready & issue_ok; other req ready = 0.
//  - issue_ok = (count < MAX_OUTSTANDING). When count == MAX_OUTSTANDING:
//    mem_req_valid = 0, no grant. A same-cycle response pop does NOT free a slot until the next cycle.
//  - Arbitration:
//    - RR: if both valid, grant = rr pointer. Pointer moves to the other port only on an accepted transfer.
//    - PRIORITY_MODE=1: port 1 wins whenever valid.
//  - Lock: if mem_req_valid & !mem_req_ready, the grant is registered and held next cycle regardless of
//    the other port. mem_req_* stay stable until accepted. Lock clears on accept.
//    Requesters must hold valid/payload stable until ready (stream rule).
//  - Accept (mem_req_valid & mem_req_ready) pushes the granted port ID into the ID FIFO; count+1.
//  - Response path is combinational: head ID H selects the destination.
//    respH_valid = mem_resp_valid & !empty; respH_data = mem_resp_data; mem_resp_ready = respH_ready & !empty.
//    The other port's resp valid = 0.
//  - Response handshake pops the FIFO; count-1.
//    Push and pop in the same cycle: count unchanged, FIFO pointers both advance (wrap at depth).
//  - mem_resp_valid with FIFO empty is a protocol error: ignored, mem_resp_ready = 0.
//    A simulation-only assertion fires.
//  - Reset mid-transaction drops all outstanding IDs. The memory must be reset together with the arbiter.
// TESTING
//  1. Only req0 valid (addr 0x40 read), mem_req_ready=1
//     -> same-cycle mem_req_addr=0x40, req0_ready=1; later result routed to resp0 only.
//  2. Both valid every cycle, RR, memory always ready
//     -> grants alternate 0,1,0,1; results return to 0,1,0,1 with the correct data.
//  3. Both valid, mem_req_ready=0 for 3 cycles with grant=1
//     -> mem_req_* frozen on port 1 for all 3 cycles; req0_ready stays 0; grant=0 after accept.
//  4. MAX_OUTSTANDING=2, two accepts with no responses
//     -> third request sees mem_req_valid=0; a response in cycle k allows issue in cycle k+1, not k.
//  5. resp1_ready=0 while the head ID is 1
//     -> mem_resp_ready=0, resp0_valid=0, no pop; releasing resp1_ready delivers the data, then resp0.
//  6. Assert rst low with 2 outstanding, release
//     -> all valids 0, count 0; the first new grant goes to port 0 when both are valid.

Source files
------------

// File: rtl/gecko_mem_port_arbiter.sv
// gecko_mem_port_arbiter
//   Shares one sequential memory port between the gecko instruction requester
//   (port 0) and data requester (port 1). Requests are arbitrated and muxed onto
//   the memory port with zero latency. The ID of each accepted request is kept in
//   an in-order ID FIFO, so each memory result is steered back to the requester
//   that issued it.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   reqN_valid/ready              request handshake, N=0 inst, N=1 data
//   reqN_write_enable/addr/data   request payload (write_enable==0 means read)
//   respN_valid/ready/data        result handshake back to requester N
//   mem_req_*                     muxed request to memory
//   mem_resp_valid/ready/data     in-order memory results (one per request)
module gecko_mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int PRIORITY_MODE   = 0,
    localparam int WE_WIDTH       = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [WE_WIDTH-1:0]   req0_write_enable,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [WE_WIDTH-1:0]   req1_write_enable,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,

    output logic                  resp0_valid,
    input  logic                  resp0_ready,
    output logic [DATA_WIDTH-1:0] resp0_data,

    output logic                  resp1_valid,
    input  logic                  resp1_ready,
    output logic [DATA_WIDTH-1:0] resp1_data,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [WE_WIDTH-1:0]   mem_req_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,

    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  logic [DATA_WIDTH-1:0] mem_resp_data
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [MAX_OUTSTANDING-1:0] id_fifo;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       rr_ptr;     // port preferred when both are valid
    logic                       lock;       // previous cycle offered but stalled
    logic                       lock_port;

    logic grant;
    logic grant_valid;
    logic issue_ok;
    logic accept;
    logic empty;
    logic head;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Slot availability looks only at the registered count, so a pop in this
    // cycle frees a slot starting next cycle.
    assign issue_ok = (count < CNT_W'(MAX_OUTSTANDING));

    // A stalled offer keeps its port so the memory sees a stable request.
    always_comb begin
        grant = 1'b0;
        if (lock)
            grant = lock_port;
        else if (PRIORITY_MODE == 1)
            grant = req1_valid;
        else if (req0_valid && req1_valid)
            grant = rr_ptr;
        else
            grant = req1_valid;
    end

    assign grant_valid          = grant ? req1_valid : req0_valid;
    assign mem_req_valid        = issue_ok & grant_valid;
    assign mem_req_write_enable = grant ? req1_write_enable : req0_write_enable;
    assign mem_req_addr         = grant ? req1_addr : req0_addr;
    assign mem_req_data         = grant ? req1_data : req0_data;
    assign accept               = mem_req_valid & mem_req_ready;

    assign req0_ready = mem_req_ready & issue_ok & ~grant & req0_valid;
    assign req1_ready = mem_req_ready & issue_ok &  grant & req1_valid;

    // Response steering by the oldest outstanding ID.
    assign empty          = (count == '0);
    assign head           = id_fifo[rd_ptr];
    assign resp0_valid    = mem_resp_valid & ~empty & ~head;
    assign resp1_valid    = mem_resp_valid & ~empty &  head;
    assign resp0_data     = mem_resp_data;
    assign resp1_data     = mem_resp_data;
    assign mem_resp_ready = ~empty & (head ? resp1_ready : resp0_ready);
    assign pop            = mem_resp_valid & mem_resp_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_fifo   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rr_ptr    <= 1'b0;
            lock      <= 1'b0;
            lock_port <= 1'b0;
        end else begin
            if (accept) begin
                id_fifo[wr_ptr] <= grant;
                wr_ptr          <= ptr_inc(wr_ptr);
                rr_ptr          <= ~grant;
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            lock      <= mem_req_valid & ~mem_req_ready;
            lock_port <= grant;
        end
    end

`ifndef SYNTHESIS
    // A memory result with nothing outstanding has no owner.
    a_resp_with_empty_fifo: assert property (@(posedge clk) disable iff (!rst)
        !(mem_resp_valid && empty));
`endif

endmodule

// File: tb/tb_gecko_mem_port_arbiter.sv
module tb_gecko_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int WW   = DW / 8;
    localparam int MAXO = 2;
    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WW-1:0] req0_write_enable, req1_write_enable, mem_req_write_enable;
    logic [AW-1:0] req0_addr, req1_addr, mem_req_addr;
    logic [DW-1:0] req0_data, req1_data, mem_req_data;
    logic          resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [DW-1:0] resp0_data, resp1_data, mem_resp_data;
    logic          mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;

    gecko_mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                             .MAX_OUTSTANDING(MAXO), .PRIORITY_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_write_enable(req0_write_enable), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_write_enable(req1_write_enable), .req1_addr(req1_addr), .req1_data(req1_data),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write_enable(mem_req_write_enable), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_data(mem_resp_data)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: in-order list of expected (owner, data), occupancy,
    // preferred port, and the port owning a stalled offer.
    typedef struct { bit port; logic [31:0] data; } exp_t;
    exp_t        m_q[$];
    logic [31:0] mem_q[$];      // memory environment's pending results
    bit          m_rr, m_lock, m_lock_port;
    int          m_cnt;
    bit          hs0, hs1;

    // Memory environment: result is a scramble of the request address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    function automatic bit e_g();
        if (m_lock) return m_lock_port;
        if (req0_valid && req1_valid) return m_rr;
        return req1_valid;
    endfunction
    function automatic bit e_mv();
        return (m_cnt < MAXO) && (req0_valid || req1_valid);
    endfunction
    function automatic bit e_r(input bit p);
        return e_mv() && (e_g() == p) && mem_req_ready;
    endfunction
    function automatic bit e_rv(input bit p);
        return mem_resp_valid && (m_q.size() > 0) && (m_q[0].port == p);
    endfunction
    function automatic bit e_mrr();
        if (m_q.size() == 0) return 1'b0;
        return m_q[0].port ? resp1_ready : resp0_ready;
    endfunction

    task automatic drive_mem(input bit en);
        mem_resp_valid = en && (mem_q.size() > 0);
        mem_resp_data  = (mem_q.size() > 0) ? mem_q[0] : '0;
    endtask

    task automatic idle_reqs();
        req0_valid = 0; req1_valid = 0;
        req0_write_enable = '0; req1_write_enable = '0;
        req0_addr = A0; req1_addr = A1; req0_data = '0; req1_data = '0;
    endtask

    task automatic model_reset();
        m_q.delete(); mem_q.delete();
        m_rr = 0; m_lock = 0; m_lock_port = 0; m_cnt = 0; hs0 = 0; hs1 = 0;
    endtask

    // Advance environment and model across one rising edge.
    task automatic tick();
        bit g, acc, pop, lk;
        logic [31:0] a;
        g   = e_g();
        acc = e_mv() && mem_req_ready;
        pop = mem_resp_valid && e_mrr();
        lk  = e_mv() && !mem_req_ready;
        a   = g ? req1_addr : req0_addr;
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        if (mem_req_valid && mem_req_ready) mem_q.push_back(mem_fn(mem_req_addr));
        if (mem_resp_valid && mem_resp_ready && mem_q.size() > 0) void'(mem_q.pop_front());
        if (pop) begin void'(m_q.pop_front()); m_cnt--; end
        if (acc) begin m_q.push_back('{port: g, data: mem_fn(a)}); m_cnt++; m_rr = !g; end
        m_lock = lk; m_lock_port = g;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        idle_reqs(); resp0_ready = 1; resp1_ready = 1;
        for (int i = 0; i < 10 && m_q.size() > 0; i++) begin
            drive_mem(1); #4; tick();
        end
        drive_mem(0);
        n_chk++;
        if (m_q.size() != 0) $display("FAIL drain: outstanding left %0d want 0", m_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 0; idle_reqs(); mem_req_ready = 0; resp0_ready = 0; resp1_ready = 0;
        model_reset(); drive_mem(0);
        @(posedge clk); #4;
        n_chk++;
        if ({mem_req_valid, req0_ready, req1_ready, resp0_valid, resp1_valid, mem_resp_ready} !== 6'b0)
            $display("FAIL reset_outputs: got %b want 000000",
                {mem_req_valid, req0_ready, req1_ready, resp0_valid, resp1_valid, mem_resp_ready});
        else n_pass++;
        @(posedge clk); #1; rst = 1; #1;
    endtask

    task automatic test_single();
        req0_valid = 1; req0_addr = 32'h40; mem_req_ready = 1; drive_mem(0); #4;
        n_chk++;
        if ({mem_req_valid, req0_ready, req1_ready} !== 3'b110)
            $display("FAIL single_hs: got %b want 110", {mem_req_valid, req0_ready, req1_ready});
        else n_pass++;
        n_chk++;
        if (mem_req_addr !== 32'h40) $display("FAIL single_addr: got %h want 00000040", mem_req_addr);
        else n_pass++;
        tick();
        req0_valid = 0; resp0_ready = 1; resp1_ready = 1; drive_mem(1); #4;
        n_chk++;
        if ({resp0_valid, resp1_valid, mem_resp_ready} !== 3'b101)
            $display("FAIL single_route: got %b want 101", {resp0_valid, resp1_valid, mem_resp_ready});
        else n_pass++;
        n_chk++;
        if (resp0_data !== mem_fn(32'h40)) $display("FAIL single_data: got %h want %h", resp0_data, mem_fn(32'h40));
        else n_pass++;
        tick(); drive_mem(0);
    endtask

    task automatic test_round_robin();
        bit want;
        want = m_rr;
        req0_valid = 1; req1_valid = 1; req0_addr = A0; req1_addr = A1;
        mem_req_ready = 1; resp0_ready = 1; resp1_ready = 1;
        for (int i = 0; i < 6; i++) begin
            drive_mem(1); #4;
            n_chk++;
            if (mem_req_addr !== (want ? A1 : A0) || !mem_req_valid)
                $display("FAIL rr_grant%0d: got addr %h want %h", i, mem_req_addr, want ? A1 : A0);
            else n_pass++;
            if (e_rv(0) || e_rv(1)) begin
                n_chk++;
                if ({resp1_valid, resp0_valid} !== {e_rv(1), e_rv(0)} ||
                    (resp0_valid ? resp0_data : resp1_data) !== m_q[0].data)
                    $display("FAIL rr_resp%0d: got v=%b d=%h want v=%b d=%h", i,
                        {resp1_valid, resp0_valid}, resp0_data, {e_rv(1), e_rv(0)}, m_q[0].data);
                else n_pass++;
            end
            tick(); want = !want;
        end
        drain();
    endtask

    task automatic test_stall_lock();
        // single port-0 transfer makes port 1 preferred next
        req0_valid = 1; mem_req_ready = 1; #4; tick(); drain();
        req0_valid = 1; req1_valid = 1; mem_req_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #4;
            n_chk++;
            if ({mem_req_valid, req0_ready, req1_ready} !== 3'b100 || mem_req_addr !== A1)
                $display("FAIL stall%0d: got v/r0/r1=%b addr %h want 100 addr %h", i,
                    {mem_req_valid, req0_ready, req1_ready}, mem_req_addr, A1);
            else n_pass++;
            tick();
        end
        mem_req_ready = 1; #4;
        n_chk++;
        if ({req0_ready, req1_ready} !== 2'b01 || mem_req_addr !== A1)
            $display("FAIL stall_accept: got r=%b addr %h want 01 addr %h", {req0_ready, req1_ready}, mem_req_addr, A1);
        else n_pass++;
        tick(); #4;
        n_chk++;
        if (mem_req_addr !== A0 || req0_ready !== 1'b1)
            $display("FAIL stall_next_grant: got addr %h r0 %b want %h 1", mem_req_addr, req0_ready, A0);
        else n_pass++;
        tick(); drain();
    endtask

    task automatic test_outstanding();
        req0_valid = 1; mem_req_ready = 1; drive_mem(0);
        req0_addr = 32'h100; #4; tick();
        req0_addr = 32'h104; #4; tick();
        req0_addr = 32'h108; #4;
        n_chk++;
        if ({mem_req_valid, req0_ready} !== 2'b00)
            $display("FAIL full_block: got %b want 00", {mem_req_valid, req0_ready});
        else n_pass++;
        tick();
        resp0_ready = 1; drive_mem(1); #4;
        n_chk++;
        if ({mem_resp_ready, mem_req_valid} !== 2'b10)
            $display("FAIL pop_no_same_cycle_issue: got %b want 10", {mem_resp_ready, mem_req_valid});
        else n_pass++;
        tick(); drive_mem(0); #4;
        n_chk++;
        if ({mem_req_valid, req0_ready} !== 2'b11 || mem_req_addr !== 32'h108)
            $display("FAIL issue_after_pop: got %b addr %h want 11 addr 00000108", {mem_req_valid, req0_ready}, mem_req_addr);
        else n_pass++;
        tick(); drain();
    endtask

    task automatic test_resp_backpressure();
        req1_valid = 1; mem_req_ready = 1; #4; tick();
        req1_valid = 0; req0_valid = 1; #4; tick();
        req0_valid = 0; resp1_ready = 0; resp0_ready = 1;
        for (int i = 0; i < 2; i++) begin
            drive_mem(1); #4;
            n_chk++;
            if ({resp1_valid, resp0_valid, mem_resp_ready} !== 3'b100)
                $display("FAIL bp_hold%0d: got %b want 100", i, {resp1_valid, resp0_valid, mem_resp_ready});
            else n_pass++;
            tick();
        end
        resp1_ready = 1; drive_mem(1); #4;
        n_chk++;
        if ({resp1_valid, mem_resp_ready} !== 2'b11 || resp1_data !== mem_fn(A1))
            $display("FAIL bp_release1: got %b d %h want 11 d %h", {resp1_valid, mem_resp_ready}, resp1_data, mem_fn(A1));
        else n_pass++;
        tick(); drive_mem(1); #4;
        n_chk++;
        if ({resp0_valid, resp1_valid} !== 2'b10 || resp0_data !== mem_fn(A0))
            $display("FAIL bp_then0: got %b d %h want 10 d %h", {resp0_valid, resp1_valid}, resp0_data, mem_fn(A0));
        else n_pass++;
        tick(); drain();
    endtask

    task automatic test_reset_mid();
        req0_valid = 1; mem_req_ready = 1; #4; tick();
        req0_valid = 0; req1_valid = 1; #4; tick();
        idle_reqs(); rst = 0; model_reset(); drive_mem(0); #4;
        n_chk++;
        if ({mem_req_valid, req0_ready, req1_ready, resp0_valid, resp1_valid, mem_resp_ready} !== 6'b0)
            $display("FAIL midreset_outputs: got %b want 000000",
                {mem_req_valid, req0_ready, req1_ready, resp0_valid, resp1_valid, mem_resp_ready});
        else n_pass++;
        @(posedge clk); #1; rst = 1;
        req0_valid = 1; req1_valid = 1; #4;
        n_chk++;
        if (!mem_req_valid || mem_req_addr !== A0)
            $display("FAIL midreset_first_grant: got v %b addr %h want 1 %h", mem_req_valid, mem_req_addr, A0);
        else n_pass++;
        tick(); #4;
        n_chk++;
        if (!mem_req_valid || mem_req_addr !== A1)
            $display("FAIL midreset_second: got v %b addr %h want 1 %h", mem_req_valid, mem_req_addr, A1);
        else n_pass++;
        tick(); #4;
        n_chk++;
        if (mem_req_valid !== 1'b0) $display("FAIL midreset_count: got v %b want 0", mem_req_valid);
        else n_pass++;
        tick(); drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid || hs0) begin
                req0_valid = ($urandom_range(0, 9) < 6); req0_addr = $urandom;
                req0_data = $urandom; req0_write_enable = WW'($urandom);
            end
            if (!req1_valid || hs1) begin
                req1_valid = ($urandom_range(0, 9) < 6); req1_addr = $urandom;
                req1_data = $urandom; req1_write_enable = WW'($urandom);
            end
            mem_req_ready = ($urandom_range(0, 3) != 0);
            resp0_ready = ($urandom_range(0, 9) < 7);
            resp1_ready = ($urandom_range(0, 9) < 7);
            drive_mem(bit'($urandom_range(0, 1)));
            #4;
            n_chk++;
            if ({mem_req_valid, req0_ready, req1_ready} !== {e_mv(), e_r(0), e_r(1)})
                $display("FAIL rnd_req c%0d: got %b want %b", c,
                    {mem_req_valid, req0_ready, req1_ready}, {e_mv(), e_r(0), e_r(1)});
            else n_pass++;
            if (e_mv()) begin
                n_chk++;
                if (mem_req_addr !== (e_g() ? req1_addr : req0_addr) ||
                    mem_req_data !== (e_g() ? req1_data : req0_data) ||
                    mem_req_write_enable !== (e_g() ? req1_write_enable : req0_write_enable))
                    $display("FAIL rnd_mux c%0d: got addr %h want %h", c, mem_req_addr,
                        e_g() ? req1_addr : req0_addr);
                else n_pass++;
            end
            n_chk++;
            if ({resp0_valid, resp1_valid, mem_resp_ready} !== {e_rv(0), e_rv(1), e_mrr()})
                $display("FAIL rnd_resp c%0d: got %b want %b", c,
                    {resp0_valid, resp1_valid, mem_resp_ready}, {e_rv(0), e_rv(1), e_mrr()});
            else n_pass++;
            if (e_rv(0) || e_rv(1)) begin
                n_chk++;
                if ((e_rv(0) ? resp0_data : resp1_data) !== m_q[0].data)
                    $display("FAIL rnd_data c%0d: got %h want %h", c,
                        e_rv(0) ? resp0_data : resp1_data, m_q[0].data);
                else n_pass++;
            end
            tick();
        end
        drain();
    endtask

    initial begin
        idle_reqs(); mem_req_ready = 0; resp0_ready = 0; resp1_ready = 0;
        mem_resp_valid = 0; mem_resp_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall_lock();
        test_outstanding();
        test_resp_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
